// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST controller: FSM states, LFSR taps, MISR polynomial.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          LFSR_W    = 5;
  // Fibonacci x^5+x^3+1: feedback is bit4 ^ bit2, shifted in at bit0
  localparam logic [4:0]  LFSR_TAPS = 5'b10100;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/c17_misr.sv
// 16-bit MISR compacting the 2-bit c17 response; clr wins over en.
// Latency: one cycle per absorbed word. No backpressure: absorbs whenever en is high.
module c17_misr
  import c17_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {14'b0, din};
    end
  end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for a c17 core: LFSR patterns out, MISR signature in, pass/fail against golden.
// Latency: NUM_PATTERNS+1 busy cycles then a one-cycle done. No backpressure: start is dropped unless IDLE.
// Optional C17_BIST_CTRL_ZERO_PATTERN_EN appends an all-zero pattern to make the run exhaustive.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int         NUM_PATTERNS = 31,
  parameter logic [4:0] SEED         = 5'h01
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] golden,
  input  logic [1:0]  cut_out,
  output logic [4:0]  cut_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [5:0]  pattern_cnt
);

`ifdef C17_BIST_CTRL_ZERO_PATTERN_EN
  localparam int LAST_CNT = NUM_PATTERNS + 1;
`else
  localparam int LAST_CNT = NUM_PATTERNS;
`endif

  state_t      state, state_nxt;
  logic        accept;
  logic [1:0]  capture_q;
  logic        capture_vld;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (pattern_cnt == 6'(LAST_CNT)) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cut_in      <= '0;
      pattern_cnt <= '0;
      pass        <= 1'b0;
      capture_q   <= '0;
      capture_vld <= 1'b0;
    end else begin
      // The response to the pattern on cut_in is captured one cycle later, so the
      // last pattern is only absorbed by the MISR on the FLUSH->DONE edge.
      capture_vld <= (state == RUN);
      if (state == RUN || state == FLUSH) capture_q <= cut_out;

      if (accept) begin
        cut_in      <= SEED;
        pattern_cnt <= 6'd1;
        pass        <= 1'b0;
      end else if (state == RUN && state_nxt == RUN) begin
`ifdef C17_BIST_CTRL_ZERO_PATTERN_EN
        if (pattern_cnt == 6'(NUM_PATTERNS)) cut_in <= '0;
        else                                 cut_in <= lfsr_next(cut_in);
`else
        cut_in <= lfsr_next(cut_in);
`endif
        pattern_cnt <= pattern_cnt + 6'd1;
      end

      if (state == DONE) pass <= (signature == golden);
    end
  end

  c17_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (capture_vld),
    .din (capture_q),
    .sig (signature)
  );

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Scoreboard bench for c17_bist_ctrl: runs at NUM_PATTERNS=31 and 1 against a behavioural c17 core.
module tb_c17_bist_ctrl;

`ifdef C17_BIST_CTRL_ZERO_PATTERN_EN
  localparam int ZP = 1;
`else
  localparam int ZP = 0;
`endif

  typedef struct {
    int          cnt;
    logic [15:0] sig;
    logic        pass;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] golden;
  int          sel;

  logic        start31, start1;
  logic [4:0]  cut_in31, cut_in1;
  logic [1:0]  cut_out31, cut_out1;
  logic        busy31, busy1, done31, done1, pass31, pass1;
  logic [15:0] sig31, sig1;
  logic [5:0]  cnt31, cnt1;

  logic [4:0]  cut_in_m;
  logic        busy_m, done_m, pass_m;
  logic [15:0] sig_m;
  logic [5:0]  cnt_m;

  int n_cmp = 0;
  int n_err = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [1:0] c17(input logic [4:0] x);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n7, n6, n3, n2, n1} = x;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [4:0] lfsr_model(input logic [4:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

  assign cut_out31 = c17(cut_in31);
  assign cut_out1  = c17(cut_in1);
  assign start31   = start && (sel == 0);
  assign start1    = start && (sel == 1);

  assign cut_in_m = sel == 1 ? cut_in1 : cut_in31;
  assign busy_m   = sel == 1 ? busy1   : busy31;
  assign done_m   = sel == 1 ? done1   : done31;
  assign pass_m   = sel == 1 ? pass1   : pass31;
  assign sig_m    = sel == 1 ? sig1    : sig31;
  assign cnt_m    = sel == 1 ? cnt1    : cnt31;

  c17_bist_ctrl #(.NUM_PATTERNS(31), .SEED(5'h01)) u31 (
    .clk(clk), .rst(rst), .start(start31), .golden(golden), .cut_out(cut_out31),
    .cut_in(cut_in31), .busy(busy31), .done(done31), .pass(pass31),
    .signature(sig31), .pattern_cnt(cnt31)
  );

  c17_bist_ctrl #(.NUM_PATTERNS(1), .SEED(5'h01)) u1 (
    .clk(clk), .rst(rst), .start(start1), .golden(golden), .cut_out(cut_out1),
    .cut_in(cut_in1), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .pattern_cnt(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One full run on the selected instance; restart_cyc/start_in_done inject ignored start pulses.
  task automatic do_run(input int s, input logic [15:0] gold_xor, input int restart_cyc,
                        input bit start_in_done);
    int          n, neff, cyc;
    logic [4:0]  p, pp;
    logic [15:0] sig;
    logic [4:0]  exp_cut[$];
    logic [31:0] seen;
    sb_t         e;

    sel  = s;
    n    = (s == 1) ? 1 : 31;
    neff = n + ZP;
    p    = 5'h01;
    sig  = 16'h0000;
    for (int i = 0; i < neff; i++) begin
      pp = (i == n) ? 5'h00 : p;
      exp_cut.push_back(pp);
      sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {14'b0, c17(pp)};
      p   = lfsr_model(p);
    end
    exp_cut.push_back(exp_cut[exp_cut.size()-1]);
    e.cnt  = neff;
    e.sig  = sig;
    e.pass = (gold_xor == 16'h0000);
    sb.push_back(e);
    golden = sig ^ gold_xor;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc  = 0;
    seen = '0;
    while (busy_m && cyc < 200) begin
      cyc++;
      if (cyc == 1) check("sig_cleared", sig_m, 16'h0000);
      if (exp_cut.size() > 0) check("cut_in_seq", cut_in_m, exp_cut.pop_front());
      check("done_while_busy", done_m, 1'b0);
      if (cyc <= neff) seen[cut_in_m] = 1'b1;
      start = (cyc == restart_cyc);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_cycles", cyc, neff + 1);
    check("distinct_patterns", $countones(seen), neff);
    check("done_pulse", done_m, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pattern_cnt", cnt_m, e.cnt);
      check("signature", sig_m, e.sig);
    end else begin
      check("sb_nonempty", 0, 1);
    end
    start = start_in_done;
    @(posedge clk); #1 start = 1'b0;
    check("done_one_cycle", done_m, 1'b0);
    check("no_restart", busy_m, 1'b0);
    check("pass", pass_m, e.pass);
    check("cnt_hold", cnt_m, e.cnt);
  endtask

  task automatic abort_run();
    int cyc;
    sel = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_in_run", busy_m, 1'b1);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    check("abort_busy", busy_m, 1'b0);
    check("abort_done", done_m, 1'b0);
    check("abort_cut_in", cut_in_m, 5'h00);
    check("abort_cnt", cnt_m, 6'd0);
    check("abort_sig", sig_m, 16'h0000);
    check("abort_pass", pass_m, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done_m, 1'b0);
      check("abort_stays_idle", busy_m, 1'b0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    golden = 16'h0000;
    sel    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cut_in", cut_in_m, 5'h00);
    check("rst_busy", busy_m, 1'b0);
    check("rst_done", done_m, 1'b0);
    check("rst_pass", pass_m, 1'b0);
    check("rst_sig", sig_m, 16'h0000);
    check("rst_cnt", cnt_m, 6'd0);
    rst = 1'b0;

    do_run(0, 16'h0000, -1, 1'b0);
    do_run(0, 16'h0001, 10, 1'b1);
    do_run(0, 16'h0000, -1, 1'b0);
    abort_run();
    do_run(1, 16'h0000, -1, 1'b0);
    do_run(1, 16'h0001, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
